// File: rtl/gf2m_mul_arbiter.sv
// Round-robin sharing of one digit-serial gf2m_mul among N_REQ requesters; one operation in flight,
// grant one cycle after request, result one cycle after mul_done; requests wait while busy, watchdog aborts a stuck multiplier.
module gf2m_mul_arbiter #(
   parameter int WIDTH   = 101,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 31
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] op_a,
   input  logic [N_REQ*WIDTH-1:0] op_b,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       res_valid,
   output logic [WIDTH-1:0]       res,
   output logic                   err,
   output logic [2:0]             err_id,
   output logic                   busy,
   output logic                   mul_start,
   output logic [WIDTH-1:0]       mul_op_a,
   output logic [WIDTH-1:0]       mul_op_b,
   input  logic                   mul_done,
   input  logic [WIDTH-1:0]       mul_op_c
);
   localparam int IDX_W  = $clog2(N_REQ);
   localparam int IDX_W1 = IDX_W + 1;
   localparam int WD_W   = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W:0]   N_REQ_W  = IDX_W1'(N_REQ);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
   localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   last, last_nxt;
   logic [IDX_W-1:0]   cur_id, cur_id_nxt;
   logic [WD_W-1:0]    wd, wd_nxt;
   logic               pick_vld;
   logic [IDX_W-1:0]   pick_id;
   logic [IDX_W:0]     cand;

   logic [N_REQ-1:0]   gnt_nxt, res_valid_nxt;
   logic [WIDTH-1:0]   res_nxt, op_a_nxt, op_b_nxt;
   logic               err_nxt, start_nxt, busy_nxt;
   logic [2:0]         err_id_nxt;

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      cand     = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, last} + IDX_W1'(k);
         if (cand >= N_REQ_W) cand = cand - N_REQ_W;
         if (!pick_vld && req[cand[IDX_W-1:0]]) begin
            pick_vld = 1'b1;
            pick_id  = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      last_nxt      = last;
      cur_id_nxt    = cur_id;
      wd_nxt        = wd;
      gnt_nxt       = '0;
      res_valid_nxt = '0;
      res_nxt       = res;
      err_nxt       = 1'b0;
      err_id_nxt    = err_id;
      start_nxt     = 1'b0;
      op_a_nxt      = mul_op_a;
      op_b_nxt      = mul_op_b;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt        = BUSY;
               gnt_nxt[pick_id] = 1'b1;
               start_nxt        = 1'b1;
               op_a_nxt         = op_a[int'(pick_id)*WIDTH +: WIDTH];
               op_b_nxt         = op_b[int'(pick_id)*WIDTH +: WIDTH];
               last_nxt         = pick_id;
               cur_id_nxt       = pick_id;
               wd_nxt           = '0;
            end
         end
         BUSY: begin
            if (mul_done) begin
               state_nxt             = IDLE;
               res_nxt               = mul_op_c;
               res_valid_nxt[cur_id] = 1'b1;
            end else if (wd == WD_MAX) begin
               state_nxt  = IDLE;
               err_nxt    = 1'b1;
               err_id_nxt = 3'(cur_id);
            end else begin
               wd_nxt = wd + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state     <= IDLE;
         last      <= LAST_RST;
         cur_id    <= '0;
         wd        <= '0;
         gnt       <= '0;
         res_valid <= '0;
         res       <= '0;
         err       <= 1'b0;
         err_id    <= '0;
         busy      <= 1'b0;
         mul_start <= 1'b0;
         mul_op_a  <= '0;
         mul_op_b  <= '0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         cur_id    <= cur_id_nxt;
         wd        <= wd_nxt;
         gnt       <= gnt_nxt;
         res_valid <= res_valid_nxt;
         res       <= res_nxt;
         err       <= err_nxt;
         err_id    <= err_id_nxt;
         busy      <= busy_nxt;
         mul_start <= start_nxt;
         mul_op_a  <= op_a_nxt;
         mul_op_b  <= op_b_nxt;
      end
   end
endmodule

// File: tb/tb_gf2m_mul_arbiter.sv
// Directed bench for gf2m_mul_arbiter with a behavioural multiplier that answers 8 cycles after start.
module tb_gf2m_mul_arbiter;
   localparam int W = 101;
   localparam int N = 4;
   localparam logic [W-1:0] POLY = 101'hC3;
   localparam logic [W-1:0] A1 = 101'h1D_CAFE_F00D_1234_5678_9ABC_DEF0;
   localparam logic [W-1:0] B2 = 101'h0A_5A5A_0F0F_FFFF_0000_1357_2468;

   logic           clk = 1'b0;
   logic           rst_b = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] op_a = '0;
   logic [N*W-1:0] op_b = '0;
   logic [N-1:0]   gnt, res_valid;
   logic [W-1:0]   res, mul_op_a, mul_op_b;
   logic           err, busy, mul_start;
   logic [2:0]     err_id;
   logic           mul_done = 1'b0;
   logic [W-1:0]   mul_op_c = '0;

   int checks = 0;
   int failures = 0;

   gf2m_mul_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT(31)) dut (
      .clk(clk), .rst_b(rst_b), .req(req), .op_a(op_a), .op_b(op_b),
      .gnt(gnt), .res_valid(res_valid), .res(res), .err(err), .err_id(err_id),
      .busy(busy), .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
      .mul_done(mul_done), .mul_op_c(mul_op_c)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] gfmul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      r = '0;
      for (int i = W-1; i >= 0; i--) begin
         r = {r[W-2:0], 1'b0} ^ (r[W-1] ? POLY : '0);
         if (b[i]) r = r ^ a;
      end
      return r;
   endfunction

   function automatic int oh2id(input logic [N-1:0] v);
      int id;
      id = -1;
      for (int i = 0; i < N; i++)
         if (v == (N'(1) << i)) id = i;
      return id;
   endfunction

   // Multiplier stand-in: done is seen in the 8th cycle after the one carrying start.
   int scnt = 0;
   bit stub_en = 1'b1;
   always @(posedge clk) begin
      if (!rst_b)               scnt = 0;
      else if (mul_start)       scnt = 1;
      else if (scnt == 8)       scnt = 0;
      else if (scnt != 0)       scnt = scnt + 1;
   end
   always @(negedge clk) begin
      mul_done = stub_en && (scnt == 8);
      mul_op_c = gfmul(mul_op_a, mul_op_b);
   end

   // Capture of one run, cycles counted from the first edge after the call.
   int           g_cyc[16], g_id[16], r_cyc[16], r_id[16], e_cyc[16];
   logic [W-1:0] r_val[16];
   int           g_n, r_n, e_n, overlap, bad_start, bad_oh;
   logic         busy_log[64], start_log[64];

   task automatic run_cycles(input int n, input bit hold, input int chg_cyc,
                             input int chg_req, input logic [W-1:0] chg_val);
      g_n = 0; r_n = 0; e_n = 0; overlap = 0; bad_start = 0; bad_oh = 0;
      for (int i = 0; i < 16; i++) begin
         g_cyc[i] = -1; g_id[i] = -1; r_cyc[i] = -1; r_id[i] = -1; e_cyc[i] = -1; r_val[i] = '0;
      end
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (c == chg_cyc) op_a[chg_req*W +: W] = chg_val;
         busy_log[c]  = busy;
         start_log[c] = mul_start;
         if ((gnt & res_valid) != '0) overlap++;
         if (mul_start && gnt == '0) bad_start++;
         if (gnt != '0) begin
            if (oh2id(gnt) < 0) bad_oh++;
            if (g_n < 16) begin g_cyc[g_n] = c; g_id[g_n] = oh2id(gnt); g_n++; end
            if (!hold) req = req & ~gnt;
         end
         if (res_valid != '0) begin
            if (oh2id(res_valid) < 0) bad_oh++;
            if (r_n < 16) begin r_cyc[r_n] = c; r_id[r_n] = oh2id(res_valid); r_val[r_n] = res; r_n++; end
         end
         if (err && e_n < 16) begin e_cyc[e_n] = c; e_n++; end
      end
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
   endtask

   task automatic test_reset();
      rst_b = 1'b0;
      req   = '1;
      repeat (2) @(negedge clk);
      checks++;
      if ({gnt, res_valid, err, busy, mul_start, err_id} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0", {gnt, res_valid, err, busy, mul_start, err_id});
      end
      checks++;
      if ({res, mul_op_a, mul_op_b} !== '0) begin
         failures++;
         $display("FAIL reset_data got res=%h a=%h b=%h exp=0", res, mul_op_a, mul_op_b);
      end
      req   = '0;
      rst_b = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      op_a[0 +: W] = A1;
      op_b[0 +: W] = 101'h1;
      req = 4'b0001;
      run_cycles(14, 1'b0, 0, 0, '0);
      checks++;
      if (g_n !== 1 || g_cyc[0] !== 1 || g_id[0] !== 0) begin
         failures++;
         $display("FAIL single_gnt got n=%0d cyc=%0d id=%0d exp n=1 cyc=1 id=0", g_n, g_cyc[0], g_id[0]);
      end
      checks++;
      if (start_log[1] !== 1'b1 || start_log[2] !== 1'b0) begin
         failures++;
         $display("FAIL single_start got c1=%b c2=%b exp c1=1 c2=0", start_log[1], start_log[2]);
      end
      checks++;
      if (r_n !== 1 || r_cyc[0] !== 10 || r_id[0] !== 0) begin
         failures++;
         $display("FAIL single_valid got n=%0d cyc=%0d id=%0d exp n=1 cyc=10 id=0", r_n, r_cyc[0], r_id[0]);
      end
      checks++;
      if (r_val[0] !== A1) begin
         failures++;
         $display("FAIL single_res got=%h exp=%h", r_val[0], A1);
      end
      checks++;
      if (busy_log[9] !== 1'b1 || busy_log[10] !== 1'b0) begin
         failures++;
         $display("FAIL single_busy got c9=%b c10=%b exp c9=1 c10=0", busy_log[9], busy_log[10]);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp_v[4];
      do_reset();
      op_a[0*W +: W] = 101'h5;            op_b[0*W +: W] = 101'h3;
      op_a[1*W +: W] = {1'b1, 100'h0};   op_b[1*W +: W] = 101'h2;
      op_a[2*W +: W] = A1;               op_b[2*W +: W] = B2;
      op_a[3*W +: W] = {1'b1, 100'h0};   op_b[3*W +: W] = {1'b1, 100'h0};
      exp_v[0] = 101'hF;
      exp_v[1] = 101'hC3;
      exp_v[2] = gfmul(A1, B2);
      exp_v[3] = gfmul({1'b1, 100'h0}, {1'b1, 100'h0});
      req = 4'b1111;
      run_cycles(45, 1'b0, 0, 0, '0);
      checks++;
      if (g_n !== 4 || r_n !== 4) begin
         failures++;
         $display("FAIL b2b_counts got gnts=%0d vals=%0d exp 4 4", g_n, r_n);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (g_cyc[i] !== 1 + 10*i || g_id[i] !== i || r_cyc[i] !== 10 + 10*i || r_id[i] !== i) begin
            failures++;
            $display("FAIL b2b_timing_%0d got gnt@%0d id%0d val@%0d id%0d exp gnt@%0d val@%0d id%0d",
                     i, g_cyc[i], g_id[i], r_cyc[i], r_id[i], 1 + 10*i, 10 + 10*i, i);
         end
         checks++;
         if (r_val[i] !== exp_v[i]) begin
            failures++;
            $display("FAIL b2b_res_%0d got=%h exp=%h", i, r_val[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_fairness();
      int idle_n;
      do_reset();
      op_a[0*W +: W] = 101'h5; op_b[0*W +: W] = 101'h3;
      op_a[2*W +: W] = A1;     op_b[2*W +: W] = B2;
      req = 4'b0101;
      run_cycles(40, 1'b1, 0, 0, '0);
      req = '0;
      checks++;
      if (g_n !== 4) begin
         failures++;
         $display("FAIL fair_count got=%0d exp=4", g_n);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (g_cyc[i] !== 1 + 10*i || g_id[i] !== ((i % 2) * 2)) begin
            failures++;
            $display("FAIL fair_gnt_%0d got cyc=%0d id=%0d exp cyc=%0d id=%0d",
                     i, g_cyc[i], g_id[i], 1 + 10*i, (i % 2) * 2);
         end
      end
      idle_n = 0;
      for (int c = 1; c <= 40; c++) if (busy_log[c] == 1'b0) idle_n++;
      checks++;
      if (idle_n !== 4 || busy_log[20] !== 1'b0 || busy_log[21] !== 1'b1) begin
         failures++;
         $display("FAIL fair_busy got idle=%0d c20=%b c21=%b exp idle=4 c20=0 c21=1",
                  idle_n, busy_log[20], busy_log[21]);
      end
      checks++;
      if (overlap !== 0 || bad_start !== 0 || bad_oh !== 0) begin
         failures++;
         $display("FAIL fair_rules got overlap=%0d start_wo_gnt=%0d not_onehot=%0d exp 0 0 0",
                  overlap, bad_start, bad_oh);
      end
      run_cycles(12, 1'b0, 0, 0, '0);
   endtask

   task automatic test_timeout();
      do_reset();
      stub_en = 1'b0;
      op_a[3*W +: W] = A1; op_b[3*W +: W] = B2;
      req = 4'b1000;
      run_cycles(36, 1'b0, 0, 0, '0);
      stub_en = 1'b1;
      checks++;
      if (g_cyc[0] !== 1 || g_id[0] !== 3) begin
         failures++;
         $display("FAIL to_gnt got cyc=%0d id=%0d exp cyc=1 id=3", g_cyc[0], g_id[0]);
      end
      checks++;
      if (e_n !== 1 || e_cyc[0] !== 33) begin
         failures++;
         $display("FAIL to_err got n=%0d cyc=%0d exp n=1 cyc=33", e_n, e_cyc[0]);
      end
      checks++;
      if (err_id !== 3'd3 || r_n !== 0) begin
         failures++;
         $display("FAIL to_id got err_id=%0d valids=%0d exp 3 0", err_id, r_n);
      end
      checks++;
      if (busy_log[32] !== 1'b1 || busy_log[33] !== 1'b0) begin
         failures++;
         $display("FAIL to_busy got c32=%b c33=%b exp 1 0", busy_log[32], busy_log[33]);
      end
      op_a[1*W +: W] = {1'b1, 100'h0}; op_b[1*W +: W] = 101'h2;
      req = 4'b0010;
      run_cycles(12, 1'b0, 0, 0, '0);
      checks++;
      if (g_cyc[0] !== 1 || g_id[0] !== 1 || r_cyc[0] !== 10 || r_val[0] !== 101'hC3) begin
         failures++;
         $display("FAIL to_recover got gnt@%0d id%0d val@%0d res=%h exp gnt@1 id1 val@10 res=c3",
                  g_cyc[0], g_id[0], r_cyc[0], r_val[0]);
      end
      checks++;
      if (err_id !== 3'd3 || e_n !== 0) begin
         failures++;
         $display("FAIL to_hold got err_id=%0d errs=%0d exp 3 0", err_id, e_n);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      op_a[2*W +: W] = A1; op_b[2*W +: W] = B2;
      req = 4'b0100;
      run_cycles(5, 1'b0, 0, 0, '0);
      checks++;
      if (g_id[0] !== 2 || busy_log[5] !== 1'b1) begin
         failures++;
         $display("FAIL rm_pre got id=%0d busy=%b exp id=2 busy=1", g_id[0], busy_log[5]);
      end
      rst_b = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      checks++;
      if ({gnt, res_valid, err, busy, mul_start} !== '0 || mul_op_a !== '0 || mul_op_b !== '0) begin
         failures++;
         $display("FAIL rm_clear got ctrl=%b a=%h b=%h exp 0", {gnt, res_valid, err, busy, mul_start},
                  mul_op_a, mul_op_b);
      end
      run_cycles(12, 1'b0, 0, 0, '0);
      checks++;
      if (r_n !== 0 || res !== '0) begin
         failures++;
         $display("FAIL rm_no_result got valids=%0d res=%h exp 0 0", r_n, res);
      end
      op_a[0*W +: W] = 101'h5; op_b[0*W +: W] = 101'h3;
      req = 4'b0101;
      run_cycles(12, 1'b0, 0, 0, '0);
      checks++;
      if (g_cyc[0] !== 1 || g_id[0] !== 0 || r_val[0] !== 101'hF) begin
         failures++;
         $display("FAIL rm_first got cyc=%0d id=%0d res=%h exp cyc=1 id=0 res=f", g_cyc[0], g_id[0], r_val[0]);
      end
      run_cycles(12, 1'b0, 0, 0, '0);
   endtask

   task automatic test_operand_stability();
      logic [W-1:0] exp_v;
      do_reset();
      op_a[0*W +: W] = A1; op_b[0*W +: W] = B2;
      exp_v = gfmul(A1, B2);
      req = 4'b0001;
      run_cycles(12, 1'b0, 2, 0, ~A1);
      checks++;
      if (r_n !== 1 || r_val[0] !== exp_v) begin
         failures++;
         $display("FAIL stab_res got n=%0d res=%h exp n=1 res=%h", r_n, r_val[0], exp_v);
      end
      checks++;
      if (mul_op_a !== A1) begin
         failures++;
         $display("FAIL stab_op_a got=%h exp=%h", mul_op_a, A1);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fairness();
      test_timeout();
      test_reset_mid();
      test_operand_stability();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gf2m_mul_arbiter.md
# gf2m_mul_arbiter

Round-robin arbiter and sequencer that shares one digit-serial `gf2m_mul` instance among `N_REQ` requesters in the ROLLO encrypt datapath.

- Accepts per-requester operand pairs through a req/gnt handshake.
- Issues a single-cycle `start` to the multiplier and waits for its `done` pulse.
- Returns the product to the granted requester with a one-hot valid pulse.
- Guards the multiplier with a watchdog timeout.

## Interface
Parameters:
- `WIDTH`, 101, field element width; must match the multiplier.
- `N_REQ`, 4, number of requesters (2..8).
- `TIMEOUT`, 31, maximum BUSY cycles to wait for `mul_done`; must exceed `DIGIT_N+1`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_b`  in  1  reset: synchronous and active-low.
- `req`  in  `N_REQ`  per-requester request level.
- `op_a`  in  `N_REQ*WIDTH`  operand a; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `op_b`  in  `N_REQ*WIDTH`  operand b, same packing as `op_a`.
- `gnt`  out  `N_REQ`  one-hot, one-cycle pulse: operands captured.
- `res_valid`  out  `N_REQ`  one-hot, one-cycle pulse: `res` is valid for that requester.
- `res`  out  `WIDTH`  product; held until the next `res_valid`.
- `err`  out  1  one-cycle pulse on timeout.
- `err_id`  out  3  index of the requester whose operation timed out; held.
- `busy`  out  1  high in every state except IDLE.
- `mul_start`  out  1  to `gf2m_mul.start`.
- `mul_op_a`, `mul_op_b`  out  `WIDTH`  to the multiplier operands; held for the whole operation.
- `mul_done`  in  1  from `gf2m_mul.done`.
- `mul_op_c`  in  `WIDTH`  from `gf2m_mul.op_c`.

## Operation
- All outputs are registered.
- Reset values:
  - `gnt`, `res_valid`, `res`, `err`, `err_id`, `mul_start`, `mul_op_a`, `mul_op_b` = 0.
  - State = IDLE, `busy` = 0, round-robin pointer `last` = `N_REQ-1`, so requester 0 has first priority.
- States and transitions:
  - IDLE: if any `req` bit is set, pick the first set bit searching `last+1, last+2, …` mod `N_REQ`.
    - Latch that requester's operands into `mul_op_a`/`mul_op_b`.
    - Set `gnt[i]` and `mul_start` for one cycle, set `last` = i, record `cur_id` = i, clear the watchdog, go to BUSY.
    - With no requests, stay in IDLE.
  - BUSY: the watchdog increments each cycle.
    - On `mul_done` = 1: register `mul_op_c` into `res`, pulse `res_valid[cur_id]`, go to IDLE.
    - Otherwise, when the watchdog reaches `TIMEOUT`: pulse `err`, set `err_id` = `cur_id`, go to IDLE with no `res_valid`.
- `mul_done` while in IDLE is ignored.
- `req` changes during BUSY are ignored. Operand changes after `gnt` do not affect the result.
- A requester holds `req` until it sees `gnt`. A requester that keeps `req` high after `gnt` is treated as a new request and rejoins round-robin order.
- The multiplier shares `rst_b`. Reset mid-operation returns to reset values immediately. An in-flight result is never delivered.

## Timing
- Let `DIGIT_N` = `WIDTH/d + 1`; this is 7 at the defaults.
- Requests are sampled at edge E0. `gnt` and `mul_start` are high in cycle 1.
- The multiplier raises `mul_done` in cycle `DIGIT_N+2` (cycle 9 at defaults).
- `res_valid` and the new `res` appear in cycle `DIGIT_N+3` (cycle 10). State is IDLE during that cycle.
- The earliest next `gnt` is cycle `DIGIT_N+4` (cycle 11). Sustained throughput is one operation per `DIGIT_N+3` cycles.
- Timeout: `err` is high in cycle `TIMEOUT+2` after E0.
- `gnt` and `res_valid` are never high in the same cycle. `mul_start` is never reasserted while BUSY.

## Test plan
- Single request, all at defaults with a real `gf2m_mul` attached:
  - Stimulus: requester 0, `op_a` = random, `op_b` = field one in the multiplier's encoding.
  - Response: `gnt` = 0001 in cycle 1, `mul_start` in cycle 1, `res_valid` = 0001 in cycle 10, `res` = `op_a`.
- All four `req` asserted at once after reset:
  - Response: grants 0, 1, 2, 3 in cycles 1, 11, 21, 31.
  - Each `res` equals the software GF(2^101) product of that requester's operands.
- Fairness:
  - Stimulus: `req[0]` and `req[2]` held high continuously.
  - Response: grants alternate 0, 2, 0, 2; `req[1]`/`req[3]` never granted; `busy` stays high except one IDLE cycle per operation.
- Timeout:
  - Stimulus: `mul_done` stubbed to 0, requester 3 requests.
  - Response: `err` pulse in cycle 33, `err_id` = 3, no `res_valid`; the next request is granted normally.
- Reset mid-operation:
  - Stimulus: `rst_b` low for one cycle at cycle 5.
  - Response: all outputs 0 the next cycle, no `res_valid` for that job. A request afterwards is granted to requester 0 first, since `last` is reset.
- Operand stability:
  - Stimulus: change `op_a` of the granted requester in cycle 2.
  - Response: `res` reflects the operands latched at E0.
